// File: rtl/burst_mem_pkg.sv
// Shared types and default widths for the burst memory target.
// Imported by the interface, the array and the top.
package burst_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    // Width of the burst length field and the remaining-beat counter.
    localparam int BEAT_W = 4;
    // Wait and read-latency counter width, covers 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCEPT,
        S_WBURST,
        S_RLAT,
        S_RBURST
    } state_t;

endpackage

// File: rtl/burst_mem_slave_if.sv
// Command/response bundle between the bus master FSM and the memory target.
// The master drives the request side; the slave answers with ready and read beats.
interface burst_mem_slave_if #(
    parameter int DATA_W = burst_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = burst_mem_pkg::ADDR_W_DEF,
    parameter int LEN_W  = burst_mem_pkg::BEAT_W
);

    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] address;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rddatavalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output wr, rd, address, length, wdata,
        input  ready, rddatavalid, rdata
    );

    modport slave (
        input  wr, rd, address, length, wdata,
        output ready, rddatavalid, rdata
    );

endinterface

// File: rtl/burst_mem_array.sv
// Register-file storage: one synchronous write port, one combinational read port.
// The whole array clears to zero on reset.
module burst_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Clear on reset, otherwise store one word when enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_slave.sv
// Burst memory target: waits, accepts one command, then streams write or read beats.
// All outputs come straight from registers updated alongside the state.
module burst_mem_slave
    import burst_mem_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int LEN_W        = BEAT_W,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 1
) (
    input logic              clock,
    input logic              reset,
    burst_mem_slave_if.slave io
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   left;
    logic               ready_q;
    logic               valid_q;
    logic [DATA_W-1:0]  rdata_q;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  raddr;
    logic [DATA_W-1:0]  mem_rdata;

    assign io.ready       = ready_q;
    assign io.rddatavalid = valid_q;
    assign io.rdata       = rdata_q;

    burst_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (io.wdata),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    // Beat 0 uses the live command address; later beats use the address counter.
    always_comb begin
        we    = 1'b0;
        waddr = addr;
        raddr = addr;
        if (state == S_ACCEPT) begin
            waddr = io.address;
            raddr = io.address;
            we    = io.wr && (io.length != '0);
        end else if (state == S_WBURST) begin
            we = io.wr;
        end
    end

    // Command sequencing, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr    <= '0;
            left    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (io.rd || io.wr) begin
                        cnt <= '0;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_ACCEPT;
                            ready_q <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (int'(cnt) >= WAIT_CYCLES - 1) begin
                        state   <= S_ACCEPT;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ACCEPT: begin
                    ready_q <= 1'b0;
                    state   <= S_IDLE;
                    cnt     <= '0;
                    if (io.wr) begin
                        addr <= io.address + ADDR_W'(1);
                        left <= io.length - LEN_W'(1);
                        if (io.length > LEN_W'(1)) begin
                            state   <= S_WBURST;
                            ready_q <= 1'b1;
                        end
                    end else if (io.rd && io.length != '0) begin
                        if (READ_LATENCY <= 1) begin
                            state   <= S_RBURST;
                            valid_q <= 1'b1;
                            rdata_q <= mem_rdata;
                            addr    <= io.address + ADDR_W'(1);
                            left    <= io.length - LEN_W'(1);
                        end else begin
                            state <= S_RLAT;
                            addr  <= io.address;
                            left  <= io.length;
                        end
                    end
                end
                S_WBURST: begin
                    if (io.wr) begin
                        addr <= addr + ADDR_W'(1);
                        left <= left - LEN_W'(1);
                        if (left == LEN_W'(1)) begin
                            state   <= S_IDLE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_RLAT: begin
                    if (int'(cnt) >= READ_LATENCY - 2) begin
                        state   <= S_RBURST;
                        valid_q <= 1'b1;
                        rdata_q <= mem_rdata;
                        addr    <= addr + ADDR_W'(1);
                        left    <= left - LEN_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RBURST: begin
                    if (left == '0) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        rdata_q <= '0;
                    end else begin
                        rdata_q <= mem_rdata;
                        addr    <= addr + ADDR_W'(1);
                        left    <= left - LEN_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_slave.sv
// Bench for burst_mem_slave: vector table, hand sequences and random traffic
// checked against a word-array model and latency arithmetic.
module tb_burst_mem_slave;

    localparam int W1  = 1;
    localparam int RL1 = 1;
    localparam int W2  = 0;
    localparam int RL2 = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    burst_mem_slave_if #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) bus ();
    burst_mem_slave_if #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) bus2 ();

    burst_mem_slave #(
        .DATA_W(32), .ADDR_W(4), .LEN_W(4),
        .WAIT_CYCLES(W1), .READ_LATENCY(RL1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    burst_mem_slave #(
        .DATA_W(32), .ADDR_W(4), .LEN_W(4),
        .WAIT_CYCLES(W2), .READ_LATENCY(RL2)
    ) dut2 (
        .clock (clock),
        .reset (reset),
        .io    (bus2)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] model [16];
    logic [31:0] tx [$];
    logic [31:0] rx [$];

    typedef struct {
        bit          w;
        bit          r;
        int          a;
        int          len;
        logic [31:0] d0;
        int          beats;
        logic [31:0] rd0;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One complete master transaction on the default-parameter target.
    task automatic xact(input bit w, input bit r, input int a, input int len,
                        input int stall_at);
        int n;
        int beat;
        bit stalled;
        bit exp_v;
        logic [31:0] exp_d;
        rx.delete();
        @(posedge clock); #1;
        bus.wr      = w;
        bus.rd      = r;
        bus.address = a[3:0];
        bus.length  = len[3:0];
        bus.wdata   = (tx.size() > 0) ? tx[0] : 32'h0;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus.ready) break;
            if (n > 40) begin
                check("ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clock); #1;
            n++;
        end
        check("accept_lat", 32'(n), 32'(1 + W1));
        if (w) begin
            beat = 1;
            stalled = 1'b0;
            while (beat < len) begin
                @(posedge clock); #1;
                if (beat == stall_at && !stalled) begin
                    stalled = 1'b1;
                    bus.wr = 1'b0;
                end else begin
                    bus.wr = 1'b1;
                    bus.wdata = tx[beat];
                    beat++;
                end
                @(negedge clock);
                check("wburst_ready", 32'(bus.ready), 32'd1);
            end
            @(posedge clock); #1;
            bus.wr = 1'b0;
            bus.rd = 1'b0;
            @(negedge clock);
            check("wr_idle_ready", 32'(bus.ready), 32'd0);
            check("wr_no_beat", 32'(bus.rddatavalid), 32'd0);
            for (int i = 0; i < len; i++) begin
                model[(a + i) % 16] = tx[i];
            end
        end else begin
            @(posedge clock); #1;
            bus.rd = 1'b0;
            for (int k = 1; k <= RL1 + len; k++) begin
                if (k > 1) begin
                    @(posedge clock); #1;
                end
                @(negedge clock);
                exp_v = (k >= RL1) && (k < RL1 + len);
                exp_d = exp_v ? model[(a + k - RL1) % 16] : 32'h0;
                check("rd_valid", 32'(bus.rddatavalid), 32'(exp_v));
                check("rd_data", bus.rdata, exp_d);
                check("rd_ready_low", 32'(bus.ready), 32'd0);
                if (bus.rddatavalid) rx.push_back(bus.rdata);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        int first;
        int vcount;
        bit exp_v;
        int stall;
        int op;
        int a;
        int len;

        bus.wr = 0; bus.rd = 0; bus.address = 0; bus.length = 0; bus.wdata = 0;
        bus2.wr = 0; bus2.rd = 0; bus2.address = 0; bus2.length = 0; bus2.wdata = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        vec[0] = '{0, 1, 4, 1, 32'h0,        1, 32'h0};
        vec[1] = '{1, 0, 4, 1, 32'hDEADBEEF, 0, 32'h0};
        vec[2] = '{0, 1, 4, 1, 32'h0,        1, 32'hDEADBEEF};
        vec[3] = '{1, 1, 5, 1, 32'h55,       0, 32'h0};
        vec[4] = '{0, 1, 5, 1, 32'h0,        1, 32'h55};
        vec[5] = '{0, 1, 9, 0, 32'h0,        0, 32'h0};
        vec[6] = '{1, 0, 7, 0, 32'h77,       0, 32'h0};
        vec[7] = '{0, 1, 7, 1, 32'h0,        1, 32'h0};
        vec[8] = '{0, 1, 3, 2, 32'h0,        2, 32'h0};

        // reset for two cycles
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_valid", 32'(bus.rddatavalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst2_ready", 32'(bus2.ready), 32'd0);
        check("rst2_valid", 32'(bus2.rddatavalid), 32'd0);
        check("rst2_rdata", bus2.rdata, 32'h0);

        // vector table
        for (int i = 0; i < 9; i++) begin
            tx.delete();
            tx.push_back(vec[i].d0);
            xact(vec[i].w, vec[i].r, vec[i].a, vec[i].len, -1);
            check("tbl_beats", 32'(rx.size()), 32'(vec[i].beats));
            if (vec[i].beats > 0) check("tbl_data", rx[0], vec[i].rd0);
        end

        // wrapping write burst with a one-cycle stall, then read back
        tx = '{32'hA, 32'hB, 32'hC};
        xact(1, 0, 14, 3, 1);
        tx.delete();
        xact(0, 1, 14, 3, -1);
        check("wrap_beats", 32'(rx.size()), 32'd3);
        if (rx.size() == 3) begin
            check("wrap_d14", rx[0], 32'hA);
            check("wrap_d15", rx[1], 32'hB);
            check("wrap_d0", rx[2], 32'hC);
        end

        // request dropped during WAIT: single ready pulse, no beats
        @(posedge clock); #1;
        bus.rd = 1'b1; bus.address = 4'd3; bus.length = 4'd1;
        pulses = 0; first = -1; vcount = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            if (bus.ready) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (bus.rddatavalid) vcount++;
            @(posedge clock); #1;
            if (k == 0) bus.rd = 1'b0;
        end
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_when", 32'(first), 32'(1 + W1));
        check("drop_valid", 32'(vcount), 32'd0);
        tx.delete();
        xact(0, 1, 4, 1, -1);
        check("drop_after", 32'(rx.size()), 32'd1);

        // reset in the middle of a three-beat read
        tx = '{32'h11, 32'h22, 32'h33};
        xact(1, 0, 8, 3, -1);
        @(posedge clock); #1;
        bus.rd = 1'b1; bus.address = 4'd8; bus.length = 4'd3;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus.ready || n > 40) break;
            @(posedge clock); #1;
            n++;
        end
        check("rst_mid_lat", 32'(n), 32'(1 + W1));
        @(posedge clock); #1;
        bus.rd = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_beat1_v", 32'(bus.rddatavalid), 32'd1);
        check("rst_mid_beat1_d", bus.rdata, 32'h11);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", 32'(bus.rddatavalid), 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'h0);
        vcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.rddatavalid) vcount++;
        end
        check("rst_mid_nobeats", 32'(vcount), 32'd0);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        tx.delete();
        xact(0, 1, 8, 1, -1);

        // zero-wait, three-cycle-latency build
        @(posedge clock); #1;
        bus2.wr = 1'b1; bus2.address = 4'd2; bus2.length = 4'd1;
        bus2.wdata = 32'hC0FFEE01;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus2.ready || n > 40) break;
            @(posedge clock); #1;
            n++;
        end
        check("d2_wr_lat", 32'(n), 32'(1 + W2));
        @(posedge clock); #1;
        bus2.wr = 1'b0;
        @(posedge clock); #1;
        bus2.rd = 1'b1; bus2.address = 4'd2; bus2.length = 4'd2;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus2.ready || n > 40) break;
            @(posedge clock); #1;
            n++;
        end
        check("d2_rd_lat", 32'(n), 32'(1 + W2));
        @(posedge clock); #1;
        bus2.rd = 1'b0;
        for (int k = 1; k <= RL2 + 2; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            @(negedge clock);
            exp_v = (k >= RL2) && (k < RL2 + 2);
            check("d2_valid", 32'(bus2.rddatavalid), 32'(exp_v));
            check("d2_data", bus2.rdata,
                  (k == RL2) ? 32'hC0FFEE01 : 32'h0);
        end

        // random traffic against the word-array model
        for (int it = 0; it < 40; it++) begin
            op  = $urandom_range(0, 2);
            a   = $urandom_range(0, 15);
            len = $urandom_range(0, 6);
            stall = $urandom_range(0, 6);
            tx.delete();
            for (int i = 0; i < 7; i++) tx.push_back($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            xact(op != 1, op != 0, a, len, stall);
        end

        // final sweep of the whole memory
        tx.delete();
        xact(0, 1, 0, 15, -1);
        xact(0, 1, 15, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_slave.md
# burst_mem_slave

Burst-capable memory target for the two-FSM bus: consumes commands (`wr`/`rd`, `address`, `length`, `wdata`) issued by the master FSM and produces the `ready` acceptance strobe, `rddatavalid` and `rdata` that the master consumes. It holds a 16 x 32-bit register-file memory and is the downstream partner of the master inside `Top`.

## Interface
Parameters:
- `DATA_W`, 32, data width of `wdata`/`rdata` and memory words
- `ADDR_W`, 4, word address width; memory depth is 2^ADDR_W
- `LEN_W`, 4, burst length field width
- `WAIT_CYCLES`, 1, idle cycles inserted between first sight of a request and `ready` (0..15)
- `READ_LATENCY`, 1, cycles from read acceptance to first `rddatavalid` beat (1..4)

Ports:
- `clock` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `io_wr` in 1: write request, held by master until accepted
- `io_rd` in 1: read request, held by master until accepted
- `io_address` in ADDR_W: start word address
- `io_length` in LEN_W: beats in burst; 0 = no data
- `io_wdata` in DATA_W: write beat data
- `io_ready` out 1: command accept strobe / write-beat enable (registered)
- `io_rddatavalid` out 1: read beat valid (registered)
- `io_rdata` out DATA_W: read beat data; 0 when `io_rddatavalid` low (registered)

## Operation
- States: IDLE, WAIT, ACCEPT, WBURST, RLAT, RBURST.
- IDLE: `io_ready`=0. `io_rd|io_wr` high -> WAIT, wait counter cleared.
- WAIT: count; after WAIT_CYCLES cycles in WAIT -> ACCEPT (WAIT_CYCLES=0 skips WAIT directly to ACCEPT).
- ACCEPT: `io_ready`=1 exactly this cycle; acceptance samples request, address, length.
  - Neither request high: no transfer, -> IDLE.
  - `io_wr` high (wins over `io_rd` if both): beat 0 `io_wdata` written to `address`; length 0 -> IDLE with no write; length 1 -> IDLE; else -> WBURST with length-1 beats remaining.
  - `io_rd` high: length 0 -> IDLE; else -> RLAT.
- WBURST: `io_ready`=1; each cycle with `io_wr`=1 writes `io_wdata` to next address and decrements remaining; `io_wr`=0 stalls. Last beat -> IDLE.
- RLAT: wait READ_LATENCY-1 cycles (0 for default), then RBURST.
- RBURST: one beat per cycle, contiguous, no stall; `io_rddatavalid`=1, `io_rdata`=mem[addr]; after `length` beats -> IDLE. `io_ready`=0; new requests held until IDLE.
- Addressing: beat address = start + beat index, modulo 2^ADDR_W (15 wraps to 0).
- Memory cleared to 0 on reset.

## Timing
- Reset: `io_ready`=0, `io_rddatavalid`=0, `io_rdata`=0, state IDLE, memory 0; effective the cycle after `reset` sampled high. Reset mid-burst aborts; remaining write beats are lost, read beats stop.
- Request first high in cycle T (IDLE) -> `io_ready` high in cycle T+1+WAIT_CYCLES (default T+2).
- Read accepted in cycle A -> beats in cycles A+READ_LATENCY .. A+READ_LATENCY+length-1.
- Write visible to a read accepted in any later cycle, including the cycle after the last write beat.
- Requests arriving during WBURST/RLAT/RBURST are ignored until IDLE; sequence restarts from IDLE. Minimum turnaround is 1 IDLE cycle.
- Request dropped during WAIT: the ACCEPT cycle still pulses `io_ready`, no transfer.

## Structure
- Package `burst_mem_pkg`: state enum, DATA_W/ADDR_W/LEN_W defaults, beat-counter width.
- Sub-module `burst_mem_array`: 2^ADDR_W x DATA_W register file, one synchronous write port, one combinational read port, synchronous clear on reset.
- Top-level holds FSM, wait/latency/beat counters, address counter, output registers.

## Test plan
- Reset for 2 cycles -> all outputs 0; read addr 4 len 1 -> `io_ready` at T+2, one beat `io_rdata`=0 at A+1.
- Write addr 4 len 1 wdata 0xDEADBEEF, then read addr 4 len 1 -> beat 0xDEADBEEF.
- Write burst addr 14 len 3, data 0xA,0xB,0xC with `io_wr` low for one cycle mid-burst -> read addr 14 len 3 returns 0xA,0xB,0xC (addresses 14,15,0), stall honored.
- Read len 0 and request dropped before ACCEPT -> `io_ready` pulses once, `io_rddatavalid` never high, state back to IDLE.
- `io_rd` and `io_wr` both high at addr 5 len 1 wdata 0x55 -> write performed, no read beat; subsequent read returns 0x55.
- Reset asserted during 3-beat read after beat 1 -> `io_rddatavalid`=0 next cycle, no further beats; WAIT_CYCLES=0, READ_LATENCY=3 build -> `io_ready` at T+1, first beat at A+3.
